// File: rtl/coeff_rd_ctrl.sv
// coeff_rd_ctrl -- reads one NxN transform block (N = 4 << size) out of the
// coefficient RAM row by row and streams the rows downstream through a
// 3-entry skid FIFO with valid/ready flow control.
//
// Ports
//   clk          sole clock, rising edge
//   rst_n        synchronous active-low reset
//   start_i      one-cycle pulse, starts a block (honoured in IDLE only)
//   size_i       block size code sampled with start_i (0..3 -> 4,8,16,32)
//   cen_o/oen_o  RAM chip/output enable, active-low, low on a read cycle
//   wen_o        RAM write enable, active-low, always high
//   addr_o       RAM row address
//   ram_data_i   RAM read data, valid the cycle after a read
//   coeff_o      block row, lane j = bits [16j+15:16j], lanes >= N zeroed
//   valid_o      coeff_o/last_o valid
//   ready_i      downstream accepts the current beat
//   last_o       marks row N-1
//   busy_o       block in progress
//   done_o       one-cycle pulse after the last row transfers
//
// state | meaning
// IDLE  | waiting for start_i
// READ  | issuing row reads while FIFO credit allows
// DRAIN | all reads issued, waiting for last-row handshake
module coeff_rd_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [1:0]   size_i,
  output logic         cen_o,
  output logic         oen_o,
  output logic         wen_o,
  output logic [4:0]   addr_o,
  input  logic [511:0] ram_data_i,
  output logic [511:0] coeff_o,
  output logic         valid_o,
  input  logic         ready_i,
  output logic         last_o,
  output logic         busy_o,
  output logic         done_o
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_e;

  state_e       state_q, state_d;
  logic [1:0]   size_q, size_d;
  logic [4:0]   row_q, row_d;
  logic [4:0]   addr_q;
  logic         pend_q;       // read issued last cycle, data on ram_data_i now
  logic         pend_last_q;  // that read was row N-1
  logic         done_q;

  logic [511:0] mem_q [3];
  logic [2:0]   last_q;
  logic [1:0]   wr_ptr_q, rd_ptr_q, cnt_q;

  logic [5:0]   n_rows;
  logic [4:0]   last_idx;
  logic         start_ok, issue, pop, head_last, row_last;
  logic [511:0] cap_data;

  assign n_rows    = 6'd4 << size_q;
  assign last_idx  = 5'(n_rows - 6'd1);
  assign row_last  = (row_q == last_idx);
  assign pop       = (cnt_q != 2'd0) && ready_i;
  assign head_last = last_q[rd_ptr_q];
  // done_q blocks a start in the done cycle so back-to-back blocks get a gap
  assign start_ok  = start_i && (state_q == IDLE) && !done_q;
  // credit: entries held + read in flight, less the entry leaving this cycle
  assign issue     = (state_q == READ) &&
                     (({1'b0, cnt_q} + {2'b0, pend_q} - {2'b0, pop}) < 3'd3);

  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    row_d   = row_q;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d = READ;
          size_d  = size_i;
          row_d   = 5'd0;
        end
      end
      READ: begin
        if (issue) begin
          row_d = row_q + 5'd1;
          if (row_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && head_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cap_data = '0;
    for (int j = 0; j < 32; j++) begin
      if (6'(j) < n_rows) cap_data[16*j +: 16] = ram_data_i[16*j +: 16];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      size_q      <= 2'd0;
      row_q       <= 5'd0;
      addr_q      <= 5'd0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      done_q      <= 1'b0;
      last_q      <= 3'b0;
      wr_ptr_q    <= 2'd0;
      rd_ptr_q    <= 2'd0;
      cnt_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      row_q       <= row_d;
      if (issue) addr_q <= row_q;
      pend_q      <= issue;
      pend_last_q <= issue && row_last;
      done_q      <= (state_q == DRAIN) && pop && head_last;
      if (pend_q) begin
        last_q[wr_ptr_q] <= pend_last_q;
        wr_ptr_q         <= (wr_ptr_q == 2'd2) ? 2'd0 : wr_ptr_q + 2'd1;
      end
      if (pop) rd_ptr_q <= (rd_ptr_q == 2'd2) ? 2'd0 : rd_ptr_q + 2'd1;
      cnt_q <= cnt_q + {1'b0, pend_q} - {1'b0, pop};
    end
  end

  // Payload needs no reset: coeff_o is gated by valid_o.
  always_ff @(posedge clk) begin
    if (pend_q) mem_q[wr_ptr_q] <= cap_data;
  end

  assign cen_o   = !issue;
  assign oen_o   = !issue;
  assign wen_o   = 1'b1;
  assign addr_o  = issue ? row_q : addr_q;
  assign valid_o = (cnt_q != 2'd0);
  assign coeff_o = valid_o ? mem_q[rd_ptr_q] : '0;
  assign last_o  = valid_o && head_last;
  assign busy_o  = (state_q != IDLE);
  assign done_o  = done_q;

endmodule

// File: tb/tb_coeff_rd_ctrl.sv
module tb_coeff_rd_ctrl;
  logic         clk = 1'b0;
  logic         rst_n, start_i, ready_i;
  logic [1:0]   size_i;
  logic         cen_o, oen_o, wen_o, valid_o, last_o, busy_o, done_o;
  logic [4:0]   addr_o;
  logic [511:0] ram_data_i, coeff_o;

  logic [15:0] ram [32][32];
  int errs   = 0;
  int checks = 0;

  coeff_rd_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .size_i(size_i),
    .cen_o(cen_o), .oen_o(oen_o), .wen_o(wen_o), .addr_o(addr_o),
    .ram_data_i(ram_data_i), .coeff_o(coeff_o), .valid_o(valid_o),
    .ready_i(ready_i), .last_o(last_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  // RAM model: data appears the cycle after a read; garbage otherwise.
  always @(posedge clk) begin
    if (cen_o == 1'b0) begin
      for (int j = 0; j < 32; j++) ram_data_i[16*j +: 16] <= ram[addr_o][j];
    end else begin
      ram_data_i <= {16{$urandom}};
    end
  end

  function automatic logic [511:0] exp_row(input int r, input int n);
    logic [511:0] v;
    v = '0;
    for (int j = 0; j < 32; j++) if (j < n) v[16*j +: 16] = ram[r][j];
    return v;
  endfunction

  task automatic fill_ram(input bit pattern);
    for (int r = 0; r < 32; r++)
      for (int j = 0; j < 32; j++)
        ram[r][j] = pattern ? 16'(r*32 + j) : 16'($urandom);
  endtask

  // rmode: 0 ready high, 1 pattern 1,0,0, 2 low for 10 cycles, 3 random
  // ign: pulse start with another size mid-block
  // abort: apply reset after this many beats (0 = run to completion)
  // chain: pulse start in the done cycle
  task automatic run_block(input int sz, input int rmode, input bit ign,
                           input int abort, input bit chain_start);
    int n, t, reads, beats, last_hs_t, first_v;
    bit held_v, done_seen, chain;
    logic [511:0] held_d;
    logic held_l;
    n = 4 << sz;
    t = 0; reads = 0; beats = 0; last_hs_t = -10; first_v = -1;
    held_v = 0; done_seen = 0; chain = 0; held_d = '0; held_l = 0;
    @(posedge clk); #1;
    start_i = 1'b1; size_i = 2'(sz);
    ready_i = (rmode == 2) ? 1'b0 : 1'b1;
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || valid_o !== 1'b0)
      $display("FAIL start_cycle: busy=%b valid=%b expected 0 0", busy_o, valid_o);
    while (!done_seen && t < 300) begin
      @(posedge clk); #1;
      t++;
      start_i = chain || (ign && t == 2);
      size_i  = (ign && t == 2) ? 2'(sz + 1) : 2'(sz ^ 1);
      chain   = 0;
      case (rmode)
        0: ready_i = 1'b1;
        1: ready_i = (t % 3 == 0);
        2: ready_i = (t > 10);
        default: ready_i = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      checks++;
      if (wen_o !== 1'b1) begin errs++; $display("FAIL wen: got %b expected 1", wen_o); end
      if (held_v) begin
        checks++;
        if (valid_o !== 1'b1 || coeff_o !== held_d || last_o !== held_l) begin
          errs++;
          $display("FAIL hold t=%0d: valid=%b last=%b data_eq=%b expected 1 %b 1",
                   t, valid_o, last_o, coeff_o === held_d, held_l);
        end
      end
      if (valid_o === 1'b1 && first_v < 0) begin
        first_v = t;
        checks++;
        if (t != 3) begin errs++; $display("FAIL lat_valid: first valid at %0d expected 3", t); end
      end
      if (valid_o === 1'b1 && ready_i) begin
        checks++;
        if (beats >= n || coeff_o !== exp_row(beats, n)) begin
          errs++;
          $display("FAIL data row %0d: got %h expected %h", beats, coeff_o[127:0],
                   exp_row(beats, n) & 512'hffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff);
        end
        checks++;
        if (last_o !== (beats == n - 1)) begin
          errs++;
          $display("FAIL last row %0d: got %b expected %b", beats, last_o, beats == n - 1);
        end
        if (rmode == 0) begin
          checks++;
          if (t != 3 + beats) begin
            errs++;
            $display("FAIL bubble row %0d: at t=%0d expected %0d", beats, t, 3 + beats);
          end
        end
        beats++;
        last_hs_t = t;
        if (beats == n && chain_start) chain = 1;
        held_v = 0;
      end else if (valid_o === 1'b1) begin
        held_v = 1; held_d = coeff_o; held_l = last_o;
      end else begin
        held_v = 0;
      end
      if (t == 1) begin
        checks++;
        if (cen_o !== 1'b0 || addr_o !== 5'd0) begin
          errs++;
          $display("FAIL lat_rd: cen=%b addr=%0d expected 0 0", cen_o, addr_o);
        end
      end
      if (cen_o === 1'b0) begin
        checks++;
        if (addr_o !== 5'(reads) || reads >= n || oen_o !== 1'b0) begin
          errs++;
          $display("FAIL rd_addr: addr=%0d oen=%b expected %0d 0 (n=%0d)", addr_o, oen_o, reads, n);
        end
        reads++;
        checks++;
        if (reads - beats > 3) begin
          errs++;
          $display("FAIL credit: outstanding=%0d expected <=3", reads - beats);
        end
      end else if (oen_o !== 1'b1) begin
        checks++; errs++;
        $display("FAIL oen_idle: got %b expected 1", oen_o);
      end
      if (rmode == 2 && t == 10) begin
        checks++;
        if (reads != 3) begin errs++; $display("FAIL stall_reads: got %0d expected 3", reads); end
      end
      if (beats == n && t == last_hs_t + 1) begin
        checks++;
        done_seen = 1;
        if (done_o !== 1'b1 || busy_o !== 1'b0) begin
          errs++;
          $display("FAIL done: done=%b busy=%b expected 1 0", done_o, busy_o);
        end
      end else begin
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b1) begin
          errs++;
          $display("FAIL busy t=%0d: done=%b busy=%b expected 0 1", t, done_o, busy_o);
        end
      end
      if (abort > 0 && beats == abort) break;
    end
    if (abort > 0) begin
      @(posedge clk); #1;
      rst_n = 1'b0; start_i = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (cen_o !== 1'b1 || oen_o !== 1'b1 || wen_o !== 1'b1 || addr_o !== 5'd0 ||
          coeff_o !== '0 || valid_o !== 1'b0 || last_o !== 1'b0 || busy_o !== 1'b0 ||
          done_o !== 1'b0) begin
        errs++;
        $display("FAIL abort_reset: cen=%b oen=%b wen=%b addr=%0d valid=%b last=%b busy=%b done=%b expected 1 1 1 0 0 0 0 0",
                 cen_o, oen_o, wen_o, addr_o, valid_o, last_o, busy_o, done_o);
      end
    end else if (!done_seen) begin
      checks++; errs++;
      $display("FAIL timeout: beats=%0d of %0d, no done", beats, n);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start_i = 1'b0; ready_i = 1'b0; size_i = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (cen_o !== 1'b1 || oen_o !== 1'b1 || wen_o !== 1'b1 || addr_o !== 5'd0 ||
        coeff_o !== '0 || valid_o !== 1'b0 || last_o !== 1'b0 || busy_o !== 1'b0 ||
        done_o !== 1'b0) begin
      errs++;
      $display("FAIL reset: cen=%b oen=%b wen=%b addr=%0d valid=%b last=%b busy=%b done=%b expected 1 1 1 0 0 0 0 0",
               cen_o, oen_o, wen_o, addr_o, valid_o, last_o, busy_o, done_o);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_size4;      fill_ram(1); run_block(0, 0, 0, 0, 0); endtask
  task automatic test_size32;     fill_ram(0); run_block(3, 0, 0, 0, 0); endtask
  task automatic test_stall_toggle; run_block(1, 1, 0, 0, 0); endtask
  task automatic test_stall_hold;   run_block(2, 2, 0, 0, 0); endtask
  task automatic test_ignore_start; run_block(1, 0, 1, 0, 0); endtask

  task automatic test_back_to_back;
    run_block(0, 0, 0, 0, 1);
    run_block(2, 3, 0, 0, 0);
  endtask

  task automatic test_reset_mid;
    run_block(1, 0, 0, 6, 0);
    run_block(1, 0, 0, 0, 0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 6; i++) begin
      fill_ram(0);
      run_block(int'($urandom_range(0, 3)), 3, 0, 0, 0);
    end
  endtask

  initial begin
    ram_data_i = '0;
    test_reset;
    test_size4;
    test_size32;
    test_stall_toggle;
    test_stall_hold;
    test_ignore_start;
    test_back_to_back;
    test_reset_mid;
    test_random;
    @(posedge clk); #1;
    start_i = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
